// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// CSR addresses and the ecall cause code.
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SAVE  = 3'd1,
        ST_VEC   = 3'd2,
        ST_RET   = 3'd3,
        ST_REDIR = 3'd4
    } state_e;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [63:0] ECALL_M = 64'd11;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause on a trap, redirects fetch to
// mtvec, and redirects to mepc on mret.
//
// state | meaning
// IDLE  | accept trap/mret, CSR read port follows the instruction path
// SAVE  | one-cycle write of mepc and mcause, trap counter bump
// VEC   | read mtvec, capture word-aligned redirect target
// RET   | read mepc, capture word-aligned redirect target
// REDIR | present redirect to fetch until accepted
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          XLEN       = 64,
    parameter logic [11:0] MTVEC_ADDR = CSR_MTVEC,
    parameter logic [11:0] MEPC_ADDR  = CSR_MEPC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_type,
    input  logic [XLEN-1:0] req_cause,
    input  logic [XLEN-1:0] req_pc,
    input  logic [11:0]     instr_csr_raddr,
    output logic [11:0]     csr_read_address,
    input  logic [XLEN-1:0] csr_read_result,
    output logic [XLEN-1:0] mepc_in,
    output logic            mepc_wen,
    output logic [XLEN-1:0] mcause_in,
    output logic            mcause_wen,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy,
    output logic [31:0]     trap_count
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [31:0]     trap_count_q, trap_count_d;
    logic [XLEN-1:0] aligned_rdata;
    logic            unused_rdata_low;

    // mtvec mode bits and any misalignment in mepc are dropped
    assign aligned_rdata    = {csr_read_result[XLEN-1:2], 2'b00};
    assign unused_rdata_low = ^csr_read_result[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            cause_q      <= '0;
            target_q     <= '0;
            trap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cause_q      <= cause_d;
            target_q     <= target_d;
            trap_count_q <= trap_count_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cause_d          = cause_q;
        target_d         = target_q;
        trap_count_d     = trap_count_q;
        req_ready        = 1'b0;
        csr_read_address = instr_csr_raddr;
        mepc_wen         = 1'b0;
        mcause_wen       = 1'b0;
        redirect_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_type) begin
                        state_d = ST_RET;
                    end else begin
                        pc_d    = req_pc;
                        cause_d = req_cause;
                        state_d = ST_SAVE;
                    end
                end
            end
            ST_SAVE: begin
                mepc_wen     = 1'b1;
                mcause_wen   = 1'b1;
                trap_count_d = trap_count_q + 32'd1;
                state_d      = ST_VEC;
            end
            ST_VEC: begin
                csr_read_address = MTVEC_ADDR;
                target_d         = aligned_rdata;
                state_d          = ST_REDIR;
            end
            ST_RET: begin
                csr_read_address = MEPC_ADDR;
                target_d         = aligned_rdata;
                state_d          = ST_REDIR;
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mepc_in     = pc_q;
    assign mcause_in   = cause_q;
    assign redirect_pc = target_q;
    assign busy        = (state_q != ST_IDLE);
    assign trap_count  = trap_count_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: table of trap/mret transactions with a
// redirect scoreboard, plus reset, read-mux and counter-wrap sequences.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_type;
    logic [XLEN-1:0] req_cause;
    logic [XLEN-1:0] req_pc;
    logic [11:0]     instr_csr_raddr;
    logic [11:0]     csr_read_address;
    logic [XLEN-1:0] csr_read_result;
    logic [XLEN-1:0] mepc_in;
    logic            mepc_wen;
    logic [XLEN-1:0] mcause_in;
    logic            mcause_wen;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            busy;
    logic [31:0]     trap_count;

    trap_ctrl #(
        .XLEN(XLEN),
        .MTVEC_ADDR(CSR_MTVEC),
        .MEPC_ADDR(CSR_MEPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_type(req_type),
        .req_cause(req_cause),
        .req_pc(req_pc),
        .instr_csr_raddr(instr_csr_raddr),
        .csr_read_address(csr_read_address),
        .csr_read_result(csr_read_result),
        .mepc_in(mepc_in),
        .mepc_wen(mepc_wen),
        .mcause_in(mcause_in),
        .mcause_wen(mcause_wen),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready),
        .busy(busy),
        .trap_count(trap_count)
    );

    typedef struct {
        logic        rtype;
        logic [63:0] pc;
        logic [63:0] cause;
        logic [63:0] mtvec;
        logic [63:0] exp_target;
        int          exp_lat;
        logic [31:0] exp_count;
        int          rdy_delay;
    } vec_t;

    vec_t        vecs[7];
    vec_t        wrap_vec;
    int          checks   = 0;
    int          failures = 0;
    int          wen_cnt  = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mtvec_m  = 64'h0;
    logic [63:0] mepc_m   = 64'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: combinational read, mepc written by the DUT's write port
    always_comb begin
        csr_read_result = {52'h0, csr_read_address};
        case (csr_read_address)
            CSR_MTVEC: csr_read_result = mtvec_m;
            CSR_MEPC:  csr_read_result = mepc_m;
            default:   csr_read_result = {52'h0, csr_read_address};
        endcase
    end

    always @(posedge clk) begin
        if (mepc_wen) mepc_m <= mepc_in;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: mid-cycle sample of write pulses and redirect handshakes
    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (mepc_wen || mcause_wen) wen_cnt++;
            if (redirect_valid && redirect_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    chk("sb_redirect_pc", redirect_pc, sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        mtvec_m        = v.mtvec;
        req_valid      = 1'b1;
        req_type       = v.rtype;
        req_pc         = v.pc;
        req_cause      = v.cause;
        redirect_ready = (v.rdy_delay == 0);
        wen_cnt        = 0;
        sb_q.push_back(v.exp_target);
        #1;
        chk($sformatf("v%0d_accept_ready", idx), req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        lat = 1;
        if (!v.rtype) begin
            chk($sformatf("v%0d_mepc_wen", idx), mepc_wen, 1);
            chk($sformatf("v%0d_mcause_wen", idx), mcause_wen, 1);
            chk($sformatf("v%0d_mepc_in", idx), mepc_in, v.pc);
            chk($sformatf("v%0d_mcause_in", idx), mcause_in, v.cause);
            chk($sformatf("v%0d_save_raddr", idx), csr_read_address, instr_csr_raddr);
        end else begin
            chk($sformatf("v%0d_ret_wen", idx), mepc_wen | mcause_wen, 0);
            chk($sformatf("v%0d_ret_raddr", idx), csr_read_address, CSR_MEPC);
        end
        chk($sformatf("v%0d_busy", idx), busy, 1);
        chk($sformatf("v%0d_busy_ready", idx), req_ready, 0);
        while (!redirect_valid && lat < 16) begin
            @(negedge clk);
            #1;
            lat++;
            if (!v.rtype && lat == 2)
                chk($sformatf("v%0d_vec_raddr", idx), csr_read_address, CSR_MTVEC);
        end
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_redir_raddr", idx), csr_read_address, instr_csr_raddr);
        if (v.rdy_delay > 0) begin
            req_valid = 1'b1;
            req_type  = 1'b0;
            req_pc    = 64'hDEAD_0000;
            req_cause = ECALL_M;
            for (int j = 0; j < v.rdy_delay; j++) begin
                chk($sformatf("v%0d_bp_valid", idx), redirect_valid, 1);
                chk($sformatf("v%0d_bp_pc", idx), redirect_pc, v.exp_target);
                chk($sformatf("v%0d_bp_busy", idx), busy, 1);
                chk($sformatf("v%0d_bp_ready", idx), req_ready, 0);
                @(negedge clk);
                #1;
            end
            redirect_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        chk($sformatf("v%0d_idle_ready", idx), req_ready, 1);
        chk($sformatf("v%0d_idle_busy", idx), busy, 0);
        chk($sformatf("v%0d_idle_valid", idx), redirect_valid, 0);
        chk($sformatf("v%0d_trap_count", idx), trap_count, v.exp_count);
        chk($sformatf("v%0d_wen_cycles", idx), wen_cnt, v.rtype ? 0 : 1);
        chk($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{1'b0, 64'h8000_0010, ECALL_M, 64'h8000_1003, 64'h8000_1000, 3, 32'd1, 0};
        vecs[1] = '{1'b0, 64'h8000_0014, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 3, 32'd2, 0};
        vecs[2] = '{1'b1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0014, 2, 32'd2, 0};
        vecs[3] = '{1'b0, 64'h0000_1234, 64'h8000_0000_0000_0007, 64'h8000_1001, 64'h8000_1000, 3, 32'd3, 5};
        vecs[4] = '{1'b1, 64'h0, 64'h0, 64'h0, 64'h0000_1234, 2, 32'd3, 5};
        vecs[5] = '{1'b0, 64'h8000_0022, 64'd3, 64'h0, 64'h0, 3, 32'd4, 0};
        vecs[6] = '{1'b1, 64'h0, 64'h0, 64'h0, 64'h8000_0020, 2, 32'd4, 2};
        wrap_vec = '{1'b0, 64'h8000_0040, ECALL_M, 64'h8000_3000, 64'h8000_3000, 3, 32'd0, 0};

        rst             = 1'b0;
        req_valid       = 1'b0;
        req_type        = 1'b0;
        req_cause       = '0;
        req_pc          = '0;
        instr_csr_raddr = CSR_MCAUSE;
        redirect_ready  = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_wen", mepc_wen | mcause_wen, 0);
        chk("rst_trap_count", trap_count, 0);
        chk("rst_mepc_in", mepc_in, 0);
        chk("rst_mcause_in", mcause_in, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_raddr_342", csr_read_address, 12'h342);
        instr_csr_raddr = 12'h123;
        #1;
        chk("idle_raddr_123", csr_read_address, 12'h123);
        instr_csr_raddr = CSR_MCAUSE;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // asynchronous reset while a redirect is pending
        @(negedge clk);
        mtvec_m        = 64'h8000_2000;
        req_valid      = 1'b1;
        req_type       = 1'b0;
        req_pc         = 64'h5555_0000;
        req_cause      = ECALL_M;
        redirect_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!redirect_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        chk("arst_reached_redir", redirect_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_redirect_valid", redirect_valid, 0);
        chk("arst_trap_count", trap_count, 0);
        chk("arst_req_ready", req_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_wen", mepc_wen | mcause_wen, 0);
        chk("arst_mepc_in", mepc_in, 0);
        chk("arst_commit_stands", mepc_m, 64'h5555_0000);
        @(negedge clk);
        rst            = 1'b1;
        redirect_ready = 1'b1;

        // counter wrap from preloaded all-ones
        @(negedge clk);
        force dut.trap_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.trap_count_q;
        #1;
        chk("wrap_preload", trap_count, 32'hFFFF_FFFF);
        run_vec(wrap_vec, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the execute stage and the CSR register file. On an ecall-style trap it writes mepc/mcause through the CSR file's direct write ports. It then reads mtvec and issues a PC redirect to fetch. On mret it reads mepc and redirects to it; while idle it passes the instruction path's CSR read address straight through to the CSR file.

## Interface
Parameters:
- XLEN, 64, datapath/CSR width
- MTVEC_ADDR, 12'h305, mtvec CSR address
- MEPC_ADDR, 12'h341, mepc CSR address

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  trap/mret request from execute
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_type  in  1  0 = trap, 1 = mret
- req_cause  in  XLEN  mcause value for trap
- req_pc  in  XLEN  PC of trapping instruction
- instr_csr_raddr  in  12  CSR read address from instruction path
- csr_read_address  out  12  to CSR file read port
- csr_read_result  in  XLEN  from CSR file, combinational
- mepc_in  out  XLEN  to CSR file
- mepc_wen  out  1  to CSR file
- mcause_in  out  XLEN  to CSR file
- mcause_wen  out  1  to CSR file
- redirect_valid  out  1  PC redirect to fetch
- redirect_pc  out  XLEN  redirect target
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  stall front end; high in every state except IDLE
- trap_count  out  32  number of traps taken

## Operation
- States: IDLE, SAVE, VEC, RET, REDIR.
- IDLE: req_ready=1. On req_valid:
  - req_type=0: latch req_pc, req_cause; go to SAVE.
  - req_type=1: go to RET.
- SAVE: for exactly one cycle, mepc_wen=1 with mepc_in=latched pc, and mcause_wen=1 with mcause_in=latched cause. trap_count increments (wraps at 2^32). Go to VEC.
- VEC: csr_read_address=MTVEC_ADDR; latch target = {csr_read_result[XLEN-1:2], 2'b00}. Direct mode only; mtvec mode bits are ignored. Go to REDIR.
- RET: csr_read_address=MEPC_ADDR; latch target = {csr_read_result[XLEN-1:2], 2'b00}. Go to REDIR.
- REDIR: redirect_valid=1; redirect_pc=target held stable. On redirect_ready, go to IDLE.
- csr_read_address = instr_csr_raddr in IDLE, REDIR and SAVE. It is the FSM address only in VEC and RET.
- Write enables are low in all states except SAVE. mepc_in/mcause_in show the latched values at all times.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE.
  - Latched pc, cause and target are 0.
  - trap_count=0.
  - mepc_wen=mcause_wen=redirect_valid=busy=0; req_ready=1.
- Trap latency (request accepted at edge 0):
  - SAVE in cycle 1; CSR updated at edge 2.
  - VEC in cycle 2.
  - redirect_valid first high in cycle 3.
- mret latency: RET in cycle 1; redirect_valid in cycle 2.
- redirect_ready already high when REDIR is entered: handshake completes in that cycle; IDLE on the next cycle.
- redirect_ready low: REDIR is held indefinitely with valid and pc stable.
- req_valid while busy: ignored (req_ready=0). The requester holds the request until it is accepted.
- Back-to-back requests: the first acceptable cycle is the IDLE cycle after the redirect handshake.
- Reset asserted mid-sequence: immediate return to IDLE with all enables low. A CSR write already committed at a prior edge stands; no partial redirect is issued.
- mtvec is not written by the sequencer, so VEC reads a stable value. An instruction-path write to mtvec is blocked by busy upstream.

## Structure
- Shared package trap_ctrl_pkg holds:
  - State enum.
  - CSR address constants 12'h305, 12'h341, 12'h342.
  - Cause constant ECALL_M = 64'd11.
- No sub-module; the FSM, latches and counter live in one module.

## Test plan
- Reset: rst low mid-REDIR → redirect_valid=0, trap_count=0, req_ready=1 immediately (asynchronous).
- Trap: req_pc=64'h8000_0010, cause=11, mtvec=64'h8000_1003 →
  - cycle 1: mepc_wen and mcause_wen high for exactly one cycle with those values.
  - cycle 3: redirect_pc=64'h8000_1000.
  - trap_count=1.
- mret: mepc=64'h8000_0014 → redirect_valid in cycle 2, redirect_pc=64'h8000_0014, no write enables.
- Backpressure: redirect_ready low for 5 cycles → redirect_pc stable, busy=1. A second req_valid is not accepted until the cycle after the handshake.
- Read mux: in IDLE, instr_csr_raddr=12'h342 → csr_read_address=12'h342. In VEC → 12'h305 regardless of instr_csr_raddr.
- Counter wrap: preload via 2^32 traps (or force) → trap_count returns to 0.
